a2d_spi_slave: RTL and testbench
================================

# a2d_spi_slave

SPI responder modelling the 8-channel, 12-bit A2D that our SPI-master sensor readers poll. It samples the master's 16-bit command, returns the conversion requested by the *previous* command, and reports each decoded channel request. It runs in the system `clk` domain and oversamples `SS_n`, `SCLK` and `MOSI` through synchronizers, so it serves as both a bench A2D model and a synthesizable FPGA stand-in.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per SPI input (≥2).
- `clk  in  1`: 50 MHz system clock.
- `rst_n  in  1`: asynchronous active-low reset.
- `SS_n  in  1`: active-low slave select from the master.
- `SCLK  in  1`: SPI clock. Idles high; mode 3 (CPOL=1, CPHA=1).
- `MOSI  in  1`: command bits, MSB first, changed by the master on SCLK fall.
- `analog  in  96`: channel k value at `[12k+11:12k]`.
- `MISO  out  1`: response bits, MSB first, changed on SCLK fall.
- `chnl  out  3`: channel decoded from the last complete command.
- `cmd_vld  out  1`: one-clk pulse when a complete 16-bit command is accepted.
- `err  out  1`: sticky malformed-transaction flag (see Configuration).

## Operation
- Inputs pass through `SYNC_STAGES` flops plus one history flop. Detected edges `ss_fall`, `ss_rise`, `sclk_fall` and `sclk_rise` are one-clk pulses.
- Command format is `{2'b00, chnl[2:0], 11'h000}`, e.g. 16'h2000 requests ch4.
- Response format is `{4'h0, analog[12*c+11:12*c]}`, where c is the channel latched from the prior complete command.
- State machine states are IDLE, SKIP, SHIFT and WAIT_HI.
  - IDLE, on `ss_fall`: load tx shift reg with the pending response, clear the bit counter, go to SKIP.
  - SKIP: the first `sclk_fall` after select is a dummy edge. Do not shift; go to SHIFT.
  - SHIFT, on `sclk_rise`: capture MOSI into the bit register and increment the 5-bit counter. The counter saturates at 16.
  - SHIFT, on `sclk_fall`: shift tx `{tx[14:0],1'b0}` and rx `{rx[14:0],mosi_bit}`.
  - `MISO` is `tx[15]` at all times.
  - Any state, on `ss_rise` with counter == 16: perform the final rx shift if one is pending, latch `chnl` = `rx_final[13:11]`, sample `analog` for that channel into the pending-response reg, pulse `cmd_vld`, then go to IDLE.
  - Any state, on `ss_rise` with counter ≠ 16: the transaction is aborted. `chnl` and the pending response are unchanged; go to IDLE.
- Reset mid-transaction: if synchronized `SS_n` is low when reset releases, go to WAIT_HI. Leave WAIT_HI only on `ss_rise`, with no `cmd_vld`.
- Simultaneous `sclk_fall` and `ss_rise` in the same clk: apply the shift first, then the end-of-transaction action.

## Timing
- Reset values: `MISO`=0, `chnl`=0, `cmd_vld`=0, `err`=0. Tx, rx and pending response are all 0, then the pending response tracks `analog` ch0 until the first accepted command.
- Edge-detect latency is `SYNC_STAGES`+1 clks after the pin edge.
- `MISO` updates one clk after detection, i.e. `SYNC_STAGES`+2 clks after the SCLK fall.
- Required SCLK half-period is ≥ `SYNC_STAGES`+4 clks. The master supplies 32 clks.
- `MISO` bit 15 is valid `SYNC_STAGES`+2 clks after SS_n falls, before the dummy SCLK fall.
- `cmd_vld` and `chnl` update one clk after the `ss_rise` detection.
- The response to transaction N carries the channel requested in transaction N-1. A master doing request-then-read gets the value on the second transfer.

## Configuration
- With `A2D_CMD_CHECK_EN` defined, `err` is set (sticky until reset) on any of:
  - an aborted transaction (counter ≠ 16 at `ss_rise`);
  - more than 16 SCLK rises;
  - a nonzero `rx[15:14]` or `rx[10:0]` in an accepted command.
- A malformed but 16-bit command is still accepted and decoded.
- Without the macro, `err` is tied 0, the check logic is absent, and unused command bits are ignored.

## Structure
- Package `a2d_pkg` holds:
  - the state enum `a2d_state_t`;
  - `CMD_CHNL_MSB`=13, `CMD_CHNL_LSB`=11;
  - `SPI_FRAME_BITS`=16;
  - `ADC_BITS`=12.
- Sub-module `spi_in_sync` (param `SYNC_STAGES`) synchronizes one input and produces level plus rise/fall pulses. It is instantiated for SS_n and SCLK; MOSI uses the level only.

## Test plan
- Basic read: ch0=12'h123, ch4=12'hABC; send 16'h2000 twice. The first response is 16'h0123 and the second is 16'h0ABC. `cmd_vld` pulses twice and `chnl`=4.
- Sweep: for c=0..7, send `{2'b00,c,11'h0}` twice each with ch c=12'h800+c. Each second response is 16'h0800+c.
- Abort: deassert SS_n after 7 SCLK rises of 16'h3800. Expect no `cmd_vld` and `chnl` unchanged. The next transfer returns the old pending value. `err`=1 with the macro, 0 without.
- Malformed command: send 16'hC001 for ch0. It is accepted with `chnl`=0; `err`=1 only with the macro.
- Reset mid-frame: assert `rst_n` low at bit 9 while SS_n stays low, then release. No `cmd_vld` until SS_n rises, and outputs show reset values. The next full frame behaves as in the basic read.
- Analog change: change ch4 after the request frame ends. The next response reflects the value sampled at the first frame's `ss_rise`, not the new value.

Source files
------------

// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D SPI responder.
// Holds the FSM state type and the command/response field layout.
package a2d_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    SHIFT   = 2'd2,
    WAIT_HI = 2'd3
  } a2d_state_t;

  localparam int CMD_CHNL_MSB   = 13;
  localparam int CMD_CHNL_LSB   = 11;
  localparam int SPI_FRAME_BITS = 16;
  localparam int ADC_BITS       = 12;
  localparam int NUM_CH         = 8;

  function automatic logic [SPI_FRAME_BITS-1:0] a2d_resp(
    input logic [NUM_CH*ADC_BITS-1:0] an,
    input logic [2:0]                 c
  );
    return {4'h0, an[ADC_BITS*c +: ADC_BITS]};
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one SPI pin with a history flop
// that turns the synchronized level into rise/fall pulses.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/a2d_spi_slave.sv
// SPI mode-3 responder modelling an 8-channel 12-bit A2D.
// Define A2D_CMD_CHECK_EN to enable the sticky malformed-frame flag err.
module a2d_spi_slave
  import a2d_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic [95:0] analog,
  output logic        MISO,
  output logic [2:0]  chnl,
  output logic        cmd_vld,
  output logic        err
);

  localparam logic [4:0] FRAME_CNT = 5'(SPI_FRAME_BITS);

  logic ss_rise, ss_fall, unused_ss_lvl;
  logic sclk_rise, sclk_fall, unused_sclk_lvl;
  logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (SS_n),
    .level_o(unused_ss_lvl),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (SCLK),
    .level_o(unused_sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (MOSI),
    .level_o(mosi_lvl),
    .rise_o (unused_mosi_rise),
    .fall_o (unused_mosi_fall)
  );

  a2d_state_t  state_q, state_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] resp_q, resp_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        bit_q, bit_d;
  logic        pend_q, pend_d;
  logic        have_q, have_d;
  logic [2:0]  chnl_q, chnl_d;
  logic        vld_q, vld_d;

  logic        shift_now, in_frame, full, accept, abort;
  logic [15:0] rx_sh, rx_fin;

  assign shift_now = (state_q == SHIFT) && sclk_fall;
  assign in_frame  = (state_q == SKIP) || (state_q == SHIFT);
  assign full      = (cnt_q == FRAME_CNT);
  assign accept    = ss_rise && in_frame && full;
  assign abort     = ss_rise && in_frame && !full;
  assign rx_sh     = {rx_q[14:0], bit_q};
  // A frame ends on an SCLK rise, so the last bit is still only in bit_q.
  assign rx_fin    = (shift_now || pend_q) ? rx_sh : rx_q;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    pend_d  = pend_q;
    have_d  = have_q;
    chnl_d  = chnl_q;
    vld_d   = 1'b0;
    resp_d  = have_q ? resp_q : a2d_resp(analog, 3'd0);

    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          tx_d    = resp_d;
          rx_d    = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = SKIP;
        end
      end
      SKIP: begin
        if (sclk_fall) state_d = SHIFT;
      end
      SHIFT: begin
        if (sclk_rise) begin
          bit_d  = mosi_lvl;
          pend_d = 1'b1;
          if (cnt_q < FRAME_CNT) cnt_d = cnt_q + 5'd1;
        end
        if (sclk_fall) begin
          tx_d   = {tx_q[14:0], 1'b0};
          rx_d   = rx_sh;
          pend_d = 1'b0;
        end
      end
      WAIT_HI: begin
      end
    endcase

    if (ss_rise) begin
      state_d = IDLE;
      if (accept) begin
        rx_d   = rx_fin;
        pend_d = 1'b0;
        chnl_d = rx_fin[CMD_CHNL_MSB:CMD_CHNL_LSB];
        resp_d = a2d_resp(analog, rx_fin[CMD_CHNL_MSB:CMD_CHNL_LSB]);
        have_d = 1'b1;
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_HI;
      tx_q    <= '0;
      rx_q    <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      pend_q  <= 1'b0;
      have_q  <= 1'b0;
      chnl_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      pend_q  <= pend_d;
      have_q  <= have_d;
      chnl_q  <= chnl_d;
      vld_q   <= vld_d;
    end
  end

`ifdef A2D_CMD_CHECK_EN
  logic err_q, err_d, ovf, bad_cmd;

  assign ovf     = (state_q == SHIFT) && sclk_rise && full;
  assign bad_cmd = accept &&
                   ((|rx_fin[15:14]) || (|rx_fin[10:0]));
  assign err_d   = err_q | abort | ovf | bad_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_chk;

  assign unused_chk = abort ^ (^rx_fin[15:14]) ^ (^rx_fin[10:0]);
  assign err        = 1'b0;
`endif

  assign MISO    = tx_q[15];
  assign chnl    = chnl_q;
  assign cmd_vld = vld_q;

endmodule

// File: tb/tb_a2d_spi_slave.sv
// Directed bench for a2d_spi_slave: mode-3 master driving 16-bit frames.
// Expected values are hand-computed from the command/response format.
module tb_a2d_spi_slave;

  localparam int HALF = 32;
`ifdef A2D_CMD_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic [95:0] analog;
  logic        MISO;
  logic [2:0]  chnl;
  logic        cmd_vld;
  logic        err;

  int tests = 0;
  int fails = 0;
  int vld_cnt = 0;

  a2d_spi_slave dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .SS_n   (SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .analog (analog),
    .MISO   (MISO),
    .chnl   (chnl),
    .cmd_vld(cmd_vld),
    .err    (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cmd_vld === 1'b1) vld_cnt++;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [11:0] v);
    analog[12*c +: 12] = v;
  endtask

  task automatic xfer(input logic [15:0] cmd, input int nrise,
                      input int rst_at, output logic [15:0] resp);
    resp = '0;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nrise; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_miso", {15'd0, MISO}, 16'h0);
        check("midrst_chnl", {13'd0, chnl}, 16'h0);
        check("midrst_vld", {15'd0, cmd_vld}, 16'h0);
        check("midrst_err", {15'd0, err}, 16'h0);
        rst_n = 1'b1;
        repeat (HALF) @(negedge clk);
      end
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      repeat (HALF) @(negedge clk);
      resp[15-i] = MISO;
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    SS_n = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  initial begin
    logic [15:0] r;
    int          v0;
    rst_n  = 1'b0;
    SS_n   = 1'b1;
    SCLK   = 1'b1;
    MOSI   = 1'b0;
    analog = '0;
    set_ch(0, 12'h123);
    set_ch(4, 12'hABC);
    repeat (4) @(negedge clk);
    check("rst_miso", {15'd0, MISO}, 16'h0);
    check("rst_chnl", {13'd0, chnl}, 16'h0);
    check("rst_vld", {15'd0, cmd_vld}, 16'h0);
    check("rst_err", {15'd0, err}, 16'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // basic read
    xfer(16'h2000, 16, -1, r);
    check("basic_r1", r, 16'h0123);
    xfer(16'h2000, 16, -1, r);
    check("basic_r2", r, 16'h0ABC);
    check("basic_vld", 16'(vld_cnt), 16'd2);
    check("basic_chnl", {13'd0, chnl}, 16'h4);
    check("basic_err", {15'd0, err}, 16'h0);

    // channel sweep
    for (int c = 0; c < 8; c++) set_ch(c, 12'h800 + 12'(c));
    for (int c = 0; c < 8; c++) begin
      logic [2:0] cc;
      cc = 3'(c);
      xfer({2'b00, cc, 11'h0}, 16, -1, r);
      xfer({2'b00, cc, 11'h0}, 16, -1, r);
      check("sweep_resp", r, 16'h0800 + 16'(c));
      check("sweep_chnl", {13'd0, chnl}, {13'd0, cc});
    end

    // aborted frame
    v0 = vld_cnt;
    xfer(16'h3800, 7, -1, r);
    check("abort_vld", 16'(vld_cnt), 16'(v0));
    check("abort_chnl", {13'd0, chnl}, 16'h7);
    check("abort_err", {15'd0, err}, {15'd0, CHK});
    xfer(16'h3800, 16, -1, r);
    check("abort_next", r, 16'h0807);

    // malformed but full-length command
    v0 = vld_cnt;
    xfer(16'hC001, 16, -1, r);
    check("mal_resp", r, 16'h0807);
    check("mal_vld", 16'(vld_cnt), 16'(v0 + 1));
    check("mal_chnl", {13'd0, chnl}, 16'h0);
    check("mal_err", {15'd0, err}, {15'd0, CHK});
    xfer(16'h0000, 16, -1, r);
    check("mal_next", r, 16'h0800);

    // reset in the middle of a frame
    set_ch(0, 12'h123);
    set_ch(4, 12'hABC);
    v0 = vld_cnt;
    xfer(16'h2000, 16, 9, r);
    check("midrst_novld", 16'(vld_cnt), 16'(v0));
    check("midrst_chnl2", {13'd0, chnl}, 16'h0);
    check("midrst_err2", {15'd0, err}, 16'h0);
    xfer(16'h2000, 16, -1, r);
    check("post_r1", r, 16'h0123);
    xfer(16'h2000, 16, -1, r);
    check("post_r2", r, 16'h0ABC);
    check("post_vld", 16'(vld_cnt), 16'(v0 + 2));
    check("post_chnl", {13'd0, chnl}, 16'h4);

    // analog change after the request is latched
    set_ch(4, 12'h555);
    xfer(16'h2000, 16, -1, r);
    check("chg_old", r, 16'h0ABC);
    xfer(16'h2000, 16, -1, r);
    check("chg_new", r, 16'h0555);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
